resp_misr_capture: RTL and testbench

- Downstream response compactor for the small FSM benchmarks.
- Consumes the benchmark's 23-bit registered-output vector (y1..y23 packed, y1 = bit 0) for a programmed number of valid cycles.
- Folds those samples into a 32-bit MISR signature and compares it against an expected signature.
- Used by the locking-evaluation harness to decide pass/fail of a key without storing full output traces.

---
 rtl/resp_misr_capture_pkg.sv | 24 ++
 rtl/resp_misr_capture_if.sv | 36 +++
 rtl/resp_misr_capture_misr_reg.sv | 42 ++++
 rtl/resp_misr_capture.sv | 136 +++++++++++++
 tb/tb_resp_misr_capture.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/resp_misr_capture_pkg.sv
// Shared definitions for the response MISR capture block.
// Holds the capture FSM state type, the default MISR polynomial and seed,
// and the single-step MISR update used by the signature register.
// No ports (package).
package resp_misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

  // One MISR step: shift left, fold the polynomial in when the MSB falls
  // off, then XOR the (already zero-extended) response word in.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] din,
                                            input logic [31:0] poly = DEFAULT_POLY);
    return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ din;
  endfunction

endpackage

// File: rtl/resp_misr_capture_if.sv
// Bus interface between the harness and resp_misr_capture.
// master: drives start, clear, len, resp_in, resp_valid, exp_sig and
//         observes busy, done, sig_out, sig_valid, match, zero_cnt.
// slave:  the capture block itself (opposite directions).
interface resp_misr_capture_if
  import resp_misr_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
);

  logic             start;
  logic             clear;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] resp_in;
  logic             resp_valid;
  logic [SIG_W-1:0] exp_sig;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] sig_out;
  logic             sig_valid;
  logic             match;
  logic [CNT_W-1:0] zero_cnt;

  modport master (
    output start, clear, len, resp_in, resp_valid, exp_sig,
    input  busy, done, sig_out, sig_valid, match, zero_cnt
  );

  modport slave (
    input  start, clear, len, resp_in, resp_valid, exp_sig,
    output busy, done, sig_out, sig_valid, match, zero_cnt
  );

endinterface

// File: rtl/resp_misr_capture_misr_reg.sv
// misr_reg: SIG_W-bit signature register.
// Ports: clk, rst (async active-low), load (reload SEED), step (apply one
// MISR update with din), din (zero-extended response), sig (current value).
// load has priority over step.
module misr_reg
  import resp_misr_pkg::*;
#(
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_nx;

  // The shared package step is 32-bit; other widths use the same rule
  // written out generically.
  generate
    if (SIG_W == 32) begin : g_pkg_step
      assign sig_nx = misr_step(sig, din, POLY);
    end else begin : g_generic_step
      assign sig_nx = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= sig_nx;
    end
  end

endmodule

// File: rtl/resp_misr_capture.sv
// resp_misr_capture: compacts a programmed number of valid response
// samples into a MISR signature and compares it with an expected value.
// Ports: clk, rst (async active-low), bus (resp_misr_capture_if.slave):
//   start/len/exp_sig request a capture, resp_in/resp_valid feed samples,
//   clear aborts; busy/done/sig_out/sig_valid/match/zero_cnt report.
// Optional macro RESP_ZERO_CNT_EN: count compacted all-zero samples in
// zero_cnt (saturating); otherwise zero_cnt is tied to 0.
module resp_misr_capture
  import resp_misr_pkg::*;
#(
  parameter int               WIDTH = 23,
  parameter int               SIG_W = 32,
  parameter int               CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input logic               clk,
  input logic               rst,
  resp_misr_capture_if.slave bus
);

  generate
    if (WIDTH > SIG_W) begin : g_bad_width
      $error("resp_misr_capture: WIDTH must not exceed SIG_W");
    end
  endgenerate

  state_t           state, state_nx;
  logic             load, step;
  logic [CNT_W-1:0] remaining;
  logic             sig_valid_q, match_q;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] din_ext;

  assign din_ext = SIG_W'(bus.resp_in);

  // Next state and the load/step strobes; clear overrides everything.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = (bus.len != '0) ? CAPTURE : DONE;
        end
      end
      CAPTURE: begin
        if (bus.resp_valid) begin
          step = 1'b1;
          if (remaining == CNT_W'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.clear) begin
      state_nx = IDLE;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // remaining only decrements on a step, and steps only happen while it
  // is at least 1, so it cannot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= bus.len;
    end else if (step) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  // Result flags: dropped on a new start, published in the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_valid_q <= 1'b0;
      match_q     <= 1'b0;
    end else if (bus.clear) begin
      sig_valid_q <= 1'b0;
    end else if (load) begin
      sig_valid_q <= 1'b0;
      match_q     <= 1'b0;
    end else if (state == DONE) begin
      sig_valid_q <= 1'b1;
      match_q     <= (sig == bus.exp_sig);
    end
  end

  misr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .din  (din_ext),
    .sig  (sig)
  );

`ifdef RESP_ZERO_CNT_EN
  logic [CNT_W-1:0] zero_cnt_q;

  // Saturating count of compacted samples that were all zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_cnt_q <= '0;
    end else if (load) begin
      zero_cnt_q <= '0;
    end else if (step && (bus.resp_in == '0) && (zero_cnt_q != '1)) begin
      zero_cnt_q <= zero_cnt_q + CNT_W'(1);
    end
  end

  assign bus.zero_cnt = zero_cnt_q;
`else
  assign bus.zero_cnt = '0;
`endif

  assign bus.busy      = (state == CAPTURE);
  assign bus.done      = (state == DONE);
  assign bus.sig_out   = sig;
  assign bus.sig_valid = sig_valid_q;
  assign bus.match     = match_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// Testbench for resp_misr_capture: randomized captures checked against a
// behavioural MISR model (plain integer arithmetic) plus fixed scenarios
// for zero length, gapped valid, abort, async reset and zero counting.
// Honours RESP_ZERO_CNT_EN for the expected zero_cnt value.
module tb_resp_misr_capture;

  localparam logic [31:0] SEED_V = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  logic [22:0] samples [64];

  resp_misr_capture_if #(.WIDTH(23), .SIG_W(32), .CNT_W(16)) bus ();

  resp_misr_capture #(.WIDTH(23), .SIG_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Signature as polynomial arithmetic over a 64-bit integer.
  function automatic logic [31:0] model_sig(input int n);
    longint unsigned s = 64'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      s = s * 2;
      if (s >= 64'h1_0000_0000) s = (s - 64'h1_0000_0000) ^ 64'h04C11DB7;
      s = s ^ {41'b0, samples[i]};
    end
    return s[31:0];
  endfunction

  function automatic int model_zeros(input int n);
    int c = 0;
`ifndef RESP_ZERO_CNT_EN
    n = 0;
`endif
    for (int i = 0; i < n; i++) if (samples[i] == 23'h0) c++;
    return c;
  endfunction

  // Starts a capture of n samples (optionally with an idle cycle after
  // each valid one) and reports the cycle done was seen, counted from the
  // start edge, and the signature at that cycle. Returns one cycle after
  // done so that sig_valid/match are observable.
  task automatic run_capture(input int n, input bit gapped, input logic [31:0] exp,
                             output int done_at, output logic [31:0] sig_at_done,
                             output bit busy_seen);
    int idx = 0;
    bit gap = 0;
    done_at = -1; sig_at_done = '0; busy_seen = 0;
    bus.start = 1; bus.len = 16'(n); bus.exp_sig = exp; bus.resp_valid = 0;
    @(posedge clk); #1;
    bus.start = 0;
    for (int c = 1; c <= 2 * n + 8; c++) begin
      if (idx < n && !(gapped && gap)) begin
        bus.resp_valid = 1; bus.resp_in = samples[idx]; idx++; gap = 1;
      end else begin
        bus.resp_valid = 0; bus.resp_in = 23'($urandom); gap = 0;
      end
      busy_seen |= bus.busy;
      if (bus.done === 1'b1) begin
        done_at = c; sig_at_done = bus.sig_out;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.resp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.sig_valid, bus.match} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 0000",
                        {bus.busy, bus.done, bus.sig_valid, bus.match});
    end
    checks++;
    if (bus.sig_out !== SEED_V) begin
      fails++; $display("[TB] FAIL reset_sig: got %h expected %h", bus.sig_out, SEED_V);
    end
    checks++;
    if (bus.zero_cnt !== 16'h0) begin
      fails++; $display("[TB] FAIL reset_zero_cnt: got %0d expected 0", bus.zero_cnt);
    end
    rst = 1;
  endtask

  task automatic test_single_zero();
    int d; logic [31:0] s; bit b;
    samples[0] = 23'h0;
    run_capture(1, 0, 32'hFB3EE249, d, s, b);
    checks++;
    if (d !== 2) begin fails++; $display("[TB] FAIL single_done_cycle: got %0d expected 2", d); end
    checks++;
    if (s !== 32'hFB3EE249) begin fails++; $display("[TB] FAIL single_sig: got %h expected fb3ee249", s); end
    checks++;
    if ({bus.sig_valid, bus.match, bus.done} !== 3'b110) begin
      fails++; $display("[TB] FAIL single_flags: got %b expected 110", {bus.sig_valid, bus.match, bus.done});
    end
    checks++;
    if (b !== 1'b1) begin fails++; $display("[TB] FAIL single_busy: got %b expected 1", b); end
  endtask

  task automatic test_zero_length();
    int d; logic [31:0] s; bit b;
    run_capture(0, 0, SEED_V, d, s, b);
    checks++;
    if (d !== 1) begin fails++; $display("[TB] FAIL zlen_done_cycle: got %0d expected 1", d); end
    checks++;
    if (s !== SEED_V) begin fails++; $display("[TB] FAIL zlen_sig: got %h expected %h", s, SEED_V); end
    checks++;
    if (b !== 1'b0) begin fails++; $display("[TB] FAIL zlen_busy: got %b expected 0", b); end
    checks++;
    if ({bus.sig_valid, bus.match} !== 2'b11) begin
      fails++; $display("[TB] FAIL zlen_flags: got %b expected 11", {bus.sig_valid, bus.match});
    end
  endtask

  task automatic test_random_captures();
    int d; logic [31:0] s, exp, ref_sig; bit b, good;
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++)
        samples[i] = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
      ref_sig = model_sig(n);
      good = 1'($urandom_range(0, 1));
      exp = good ? ref_sig : ref_sig ^ (32'h1 << $urandom_range(0, 31));
      run_capture(n, 0, exp, d, s, b);
      checks++;
      if (d !== n + 1) begin fails++; $display("[TB] FAIL rand_done_cycle[%0d]: got %0d expected %0d", it, d, n + 1); end
      checks++;
      if (s !== ref_sig) begin fails++; $display("[TB] FAIL rand_sig[%0d]: got %h expected %h", it, s, ref_sig); end
      checks++;
      if ({bus.sig_valid, bus.match} !== {1'b1, good}) begin
        fails++; $display("[TB] FAIL rand_match[%0d]: got %b expected %b", it, {bus.sig_valid, bus.match}, {1'b1, good});
      end
      checks++;
      if (bus.zero_cnt !== 16'(model_zeros(n))) begin
        fails++; $display("[TB] FAIL rand_zero_cnt[%0d]: got %0d expected %0d", it, bus.zero_cnt, model_zeros(n));
      end
    end
  endtask

  task automatic test_gapped();
    int d1, d2; logic [31:0] s1, s2; bit b;
    for (int i = 0; i < 3; i++) samples[i] = 23'($urandom);
    run_capture(3, 0, 32'h0, d1, s1, b);
    run_capture(3, 1, 32'h0, d2, s2, b);
    checks++;
    if (d1 !== 4) begin fails++; $display("[TB] FAIL gap_b2b_done: got %0d expected 4", d1); end
    checks++;
    if (d2 !== 6) begin fails++; $display("[TB] FAIL gap_done: got %0d expected 6", d2); end
    checks++;
    if (s2 !== model_sig(3)) begin fails++; $display("[TB] FAIL gap_sig: got %h expected %h", s2, model_sig(3)); end
    checks++;
    if (s1 !== model_sig(3)) begin fails++; $display("[TB] FAIL gap_b2b_sig: got %h expected %h", s1, model_sig(3)); end
  endtask

  task automatic test_abort();
    int d; logic [31:0] s; bit b, saw_done;
    for (int i = 0; i < 2; i++) samples[i] = 23'($urandom);
    run_capture(2, 0, 32'h0, d, s, b);
    bus.clear = 1; @(posedge clk); #1; bus.clear = 0;
    checks++;
    if ({bus.sig_valid, bus.sig_out} !== {1'b0, model_sig(2)}) begin
      fails++; $display("[TB] FAIL idle_clear: got %b/%h expected 0/%h", bus.sig_valid, bus.sig_out, model_sig(2));
    end
    for (int i = 0; i < 10; i++) samples[i] = 23'($urandom);
    bus.start = 1; bus.len = 16'd10; @(posedge clk); #1; bus.start = 0;
    for (int i = 0; i < 4; i++) begin
      bus.resp_valid = 1; bus.resp_in = samples[i]; @(posedge clk); #1;
    end
    bus.clear = 1; bus.start = 1; bus.resp_valid = 1; bus.resp_in = samples[4];
    @(posedge clk); #1;
    bus.clear = 0; bus.start = 0; bus.resp_valid = 0;
    checks++;
    if ({bus.busy, bus.done, bus.sig_valid} !== 3'b000) begin
      fails++; $display("[TB] FAIL abort_flags: got %b expected 000", {bus.busy, bus.done, bus.sig_valid});
    end
    checks++;
    if (bus.sig_out !== model_sig(4)) begin
      fails++; $display("[TB] FAIL abort_sig: got %h expected %h", bus.sig_out, model_sig(4));
    end
    saw_done = 0;
    for (int c = 0; c < 6; c++) begin saw_done |= bus.done; @(posedge clk); #1; end
    checks++;
    if (saw_done !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_done: got %b expected 0", saw_done); end
    for (int i = 0; i < 5; i++) samples[i] = 23'($urandom);
    run_capture(5, 0, model_sig(5), d, s, b);
    checks++;
    if ({d == 6, s} !== {1'b1, model_sig(5)}) begin
      fails++; $display("[TB] FAIL abort_restart: got done@%0d sig %h expected done@6 sig %h", d, s, model_sig(5));
    end
  endtask

  task automatic test_async_reset();
    int d; logic [31:0] s; bit b;
    for (int i = 0; i < 12; i++) samples[i] = 23'($urandom);
    bus.start = 1; bus.len = 16'd12; @(posedge clk); #1; bus.start = 0;
    for (int i = 0; i < 5; i++) begin
      bus.resp_valid = 1; bus.resp_in = samples[i]; @(posedge clk); #1;
    end
    bus.resp_in = samples[5];
    #2 rst = 0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sig_valid, bus.match} !== 4'b0000) begin
      fails++; $display("[TB] FAIL arst_flags: got %b expected 0000", {bus.busy, bus.done, bus.sig_valid, bus.match});
    end
    checks++;
    if ({bus.sig_out, bus.zero_cnt} !== {SEED_V, 16'h0}) begin
      fails++; $display("[TB] FAIL arst_sig: got %h/%0d expected %h/0", bus.sig_out, bus.zero_cnt, SEED_V);
    end
    rst = 1;
    @(posedge clk); #1;
    bus.resp_valid = 0;
    for (int i = 0; i < 7; i++) samples[i] = 23'($urandom);
    run_capture(7, 0, 32'h0, d, s, b);
    checks++;
    if ({d == 8, s} !== {1'b1, model_sig(7)}) begin
      fails++; $display("[TB] FAIL arst_recapture: got done@%0d sig %h expected done@8 sig %h", d, s, model_sig(7));
    end
  endtask

  task automatic test_zero_cnt();
    int d; logic [31:0] s; bit b; logic [15:0] exp_cnt;
    for (int i = 0; i < 8; i++) samples[i] = 23'($urandom_range(1, 23'h7FFFFF));
    samples[1] = 23'h0; samples[4] = 23'h0; samples[6] = 23'h0;
`ifdef RESP_ZERO_CNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    run_capture(8, 0, 32'h0, d, s, b);
    checks++;
    if (bus.zero_cnt !== exp_cnt) begin
      fails++; $display("[TB] FAIL zero_cnt: got %0d expected %0d", bus.zero_cnt, exp_cnt);
    end
    checks++;
    if (s !== model_sig(8)) begin fails++; $display("[TB] FAIL zero_cnt_sig: got %h expected %h", s, model_sig(8)); end
  endtask

  initial begin
    rst = 0;
    bus.start = 0; bus.clear = 0; bus.len = '0;
    bus.resp_in = '0; bus.resp_valid = 0; bus.exp_sig = '0;
    test_reset();
    test_single_zero();
    test_zero_length();
    test_random_captures();
    test_gapped();
    test_abort();
    test_async_reset();
    test_zero_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
